// File: rtl/brush_stroke_plotter_if.sv
// Framebuffer pixel-write channel: one pixel per accepted valid/ready handshake.
// The plotter is the master; the framebuffer side is the slave.
interface brush_stroke_plotter_if #(
    parameter int COLOUR_W = 3
);
    logic                pix_valid;
    logic                pix_ready;
    logic [9:0]          pix_x;
    logic [8:0]          pix_y;
    logic [COLOUR_W-1:0] pix_colour;

    modport master (
        output pix_valid,
        output pix_x,
        output pix_y,
        output pix_colour,
        input  pix_ready
    );

    modport slave (
        input  pix_valid,
        input  pix_x,
        input  pix_y,
        input  pix_colour,
        output pix_ready
    );
endinterface

// File: rtl/brush_stroke_plotter.sv
// Draws a continuous brush stroke while the left mouse button is held: successive
// cursor samples are joined by a Bresenham line and a square brush is stamped per point.
//
// state | meaning
// IDLE  | waiting for pen down / cursor motion; starts a new line segment
// STAMP | scanning the BRUSH x BRUSH square around (px,py), one pixel per cycle
// STEP  | one Bresenham step toward (x1,y1)
module brush_stroke_plotter #(
    parameter int BRUSH    = 3,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int COLOUR_W = 3
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    input  logic signed [10:0]     cursor_x,
    input  logic signed [10:0]     cursor_y,
    input  logic                   left_button,
    input  logic [COLOUR_W-1:0]    colour_in,
    brush_stroke_plotter_if.master pix,
    output logic                   busy
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_STAMP = 2'd1;
    localparam logic [1:0] S_STEP  = 2'd2;

    localparam logic signed [11:0] HALF  = 12'((BRUSH - 1) / 2);
    localparam logic signed [11:0] X_LIM = 12'(SCREEN_W);
    localparam logic signed [11:0] Y_LIM = 12'(SCREEN_H);
    localparam logic signed [10:0] X_MAX = 11'(SCREEN_W - 1);
    localparam logic signed [10:0] Y_MAX = 11'(SCREEN_H - 1);
    localparam logic [3:0]         B_LAST = 4'(BRUSH - 1);

    logic [1:0]          state;
    logic                pen_down;
    logic [9:0]          last_x;
    logic [8:0]          last_y;
    logic signed [11:0]  x1, y1, px, py, dx, dy, err;
    logic                sx_neg, sy_neg;
    logic [3:0]          bx, by;
    logic [COLOUR_W-1:0] colour_r;

    logic [9:0]          cx;
    logic [8:0]          cy;
    logic signed [11:0]  cx_s, cy_s, x0_s, y0_s, adx, ady;
    logic                start;
    logic signed [11:0]  cand_x, cand_y;
    logic                in_range, advance, at_end;
    logic signed [12:0]  e2, dx13, dy13;
    logic                step_x, step_y;
    logic signed [11:0]  err_step;

    always_comb begin
        cx = cursor_x[9:0];
        if (cursor_x[10])
            cx = '0;
        else if (cursor_x > X_MAX)
            cx = X_MAX[9:0];

        cy = cursor_y[8:0];
        if (cursor_y[10])
            cy = '0;
        else if (cursor_y > Y_MAX)
            cy = Y_MAX[8:0];
    end

    // A pen already down continues from the last drawn point; a fresh press is a dot.
    always_comb begin
        cx_s  = {2'b00, cx};
        cy_s  = {3'b000, cy};
        x0_s  = pen_down ? {2'b00, last_x} : cx_s;
        y0_s  = pen_down ? {3'b000, last_y} : cy_s;
        adx   = (cx_s >= x0_s) ? (cx_s - x0_s) : (x0_s - cx_s);
        ady   = (cy_s >= y0_s) ? (cy_s - y0_s) : (y0_s - cy_s);
        start = left_button && (!pen_down || (cx != last_x) || (cy != last_y));
    end

    always_comb begin
        cand_x   = px + $signed({8'b0, bx}) - HALF;
        cand_y   = py + $signed({8'b0, by}) - HALF;
        in_range = (cand_x >= 12'sd0) && (cand_x < X_LIM) &&
                   (cand_y >= 12'sd0) && (cand_y < Y_LIM);
        advance  = (state == S_STAMP) && (!in_range || pix.pix_ready);
        at_end   = (px == x1) && (py == y1);
    end

    // Both step decisions use the error value from before this step.
    always_comb begin
        e2       = {err, 1'b0};
        dx13     = {dx[11], dx};
        dy13     = {dy[11], dy};
        step_x   = (e2 >= dy13);
        step_y   = (e2 <= dx13);
        err_step = err + (step_x ? dy : 12'sd0) + (step_y ? dx : 12'sd0);
    end

    always_comb begin
        pix.pix_valid  = (state == S_STAMP) && in_range;
        pix.pix_x      = pix.pix_valid ? cand_x[9:0] : '0;
        pix.pix_y      = pix.pix_valid ? cand_y[8:0] : '0;
        pix.pix_colour = pix.pix_valid ? colour_r : '0;
        busy           = (state != S_IDLE);
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            pen_down <= 1'b0;
            last_x   <= '0;
            last_y   <= '0;
            x1       <= '0;
            y1       <= '0;
            px       <= '0;
            py       <= '0;
            dx       <= '0;
            dy       <= '0;
            err      <= '0;
            sx_neg   <= 1'b0;
            sy_neg   <= 1'b0;
            bx       <= '0;
            by       <= '0;
            colour_r <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!left_button) begin
                        pen_down <= 1'b0;
                    end else if (start) begin
                        x1       <= cx_s;
                        y1       <= cy_s;
                        px       <= x0_s;
                        py       <= y0_s;
                        dx       <= adx;
                        dy       <= -ady;
                        err      <= adx - ady;
                        sx_neg   <= (cx_s < x0_s);
                        sy_neg   <= (cy_s < y0_s);
                        colour_r <= colour_in;
                        pen_down <= 1'b1;
                        bx       <= '0;
                        by       <= '0;
                        state    <= S_STAMP;
                    end
                end
                S_STAMP: begin
                    if (advance) begin
                        if (bx != B_LAST) begin
                            bx <= bx + 4'd1;
                        end else begin
                            bx <= '0;
                            if (by != B_LAST) begin
                                by <= by + 4'd1;
                            end else begin
                                by <= '0;
                                if (at_end) begin
                                    last_x <= x1[9:0];
                                    last_y <= y1[8:0];
                                    state  <= S_IDLE;
                                end else begin
                                    state  <= S_STEP;
                                end
                            end
                        end
                    end
                end
                S_STEP: begin
                    err <= err_step;
                    if (step_x)
                        px <= sx_neg ? (px - 12'sd1) : (px + 12'sd1);
                    if (step_y)
                        py <= sy_neg ? (py - 12'sd1) : (py + 12'sd1);
                    bx    <= '0;
                    by    <= '0;
                    state <= S_STAMP;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_brush_stroke_plotter.sv
// Scoreboard bench for brush_stroke_plotter: a line/brush reference model queues the
// expected pixel writes, and a monitor pops and compares each accepted handshake.
module tb_brush_stroke_plotter;
    localparam int BRUSH    = 3;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int COLOUR_W = 3;
    localparam int H        = (BRUSH - 1) / 2;

    typedef struct {
        int x;
        int y;
        int c;
    } pix_t;

    logic                    CLOCK_50 = 1'b0;
    logic                    reset = 1'b1;
    logic signed [10:0]      cursor_x = '0;
    logic signed [10:0]      cursor_y = '0;
    logic                    left_button = 1'b0;
    logic [COLOUR_W-1:0]     colour_in = '0;
    logic                    busy;

    brush_stroke_plotter_if #(.COLOUR_W(COLOUR_W)) pix ();

    brush_stroke_plotter #(
        .BRUSH(BRUSH), .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H), .COLOUR_W(COLOUR_W)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .cursor_x    (cursor_x),
        .cursor_y    (cursor_y),
        .left_button (left_button),
        .colour_in   (colour_in),
        .pix         (pix),
        .busy        (busy)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int   n_checks = 0;
    int   n_pass = 0;
    int   writes = 0;
    int   seg_w0 = 0;
    int   ready_mode = 0;
    pix_t exp_q[$];
    bit   m_pen = 1'b0;
    int   m_lx = 0;
    int   m_ly = 0;
    int   m_pushes = 0;

    // 0: always ready, 1: random, 2: stalled
    always @(posedge CLOCK_50) begin
        #1;
        case (ready_mode)
            0:       pix.pix_ready = 1'b1;
            1:       pix.pix_ready = 1'($urandom_range(0, 1));
            default: pix.pix_ready = 1'b0;
        endcase
    end

    task automatic chk(input string name, input bit ok, input int act, input int req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    task automatic monitor();
        pix_t e;
        forever begin
            @(negedge CLOCK_50);
            if (!reset && pix.pix_valid && pix.pix_ready) begin
                writes++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_write_x", 1'b0, int'(pix.pix_x), -1);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_x", int'(pix.pix_x) == e.x, int'(pix.pix_x), e.x);
                    chk("write_y", int'(pix.pix_y) == e.y, int'(pix.pix_y), e.y);
                    chk("write_colour", int'(pix.pix_colour) == e.c, int'(pix.pix_colour), e.c);
                end
            end
        end
    endtask

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic push_stamp(input int px, input int py, input int c);
        pix_t p;
        for (int j = 0; j < BRUSH; j++)
            for (int i = 0; i < BRUSH; i++) begin
                p.x = px + i - H;
                p.y = py + j - H;
                p.c = c;
                if (p.x >= 0 && p.x < SCREEN_W && p.y >= 0 && p.y < SCREEN_H) begin
                    exp_q.push_back(p);
                    m_pushes++;
                end
            end
    endtask

    // Reference: textbook integer Bresenham from the previous point (or a dot on a fresh press).
    task automatic model_segment(input int x, input int y, input int c, output bit started);
        int cx, cy, x0, y0, ddx, ddy, sx, sy, err, e2, px, py;
        cx = clampi(x, SCREEN_W - 1);
        cy = clampi(y, SCREEN_H - 1);
        started  = !m_pen || cx != m_lx || cy != m_ly;
        m_pushes = 0;
        if (started) begin
            x0  = m_pen ? m_lx : cx;
            y0  = m_pen ? m_ly : cy;
            ddx = (cx > x0) ? cx - x0 : x0 - cx;
            ddy = -((cy > y0) ? cy - y0 : y0 - cy);
            sx  = (x0 < cx) ? 1 : -1;
            sy  = (y0 < cy) ? 1 : -1;
            err = ddx + ddy;
            px  = x0;
            py  = y0;
            for (int k = 0; k < 2000; k++) begin
                push_stamp(px, py, c);
                if (px == cx && py == cy) break;
                e2 = 2 * err;
                if (e2 >= ddy) begin err += ddy; px += sx; end
                if (e2 <= ddx) begin err += ddx; py += sy; end
            end
            m_lx  = cx;
            m_ly  = cy;
            m_pen = 1'b1;
        end
    endtask

    task automatic seg_start(input int x, input int y, input int c,
                             output bit started, output bit first_valid);
        int n;
        seg_w0      = writes;
        cursor_x    = 11'(x);
        cursor_y    = 11'(y);
        colour_in   = COLOUR_W'(c);
        left_button = 1'b1;
        model_segment(x, y, c, started);
        first_valid = 1'b0;
        if (started) begin
            n = 0;
            do begin
                @(negedge CLOCK_50);
                n++;
            end while (!busy && n < 4);
            chk("busy_rise", busy, int'(busy), 1);
            first_valid = pix.pix_valid;
        end
    endtask

    task automatic seg_finish(input bit started, output int idle);
        int n;
        idle = 0;
        if (started) begin
            n = 0;
            while (busy && n < 20000) begin
                if (!pix.pix_valid) idle++;
                @(negedge CLOCK_50);
                n++;
            end
            chk("busy_fall", !busy, int'(busy), 0);
        end else begin
            repeat (3) @(negedge CLOCK_50);
        end
        @(posedge CLOCK_50);
        #1;
        chk("seg_writes", (writes - seg_w0) == m_pushes, writes - seg_w0, m_pushes);
        chk("seg_drain", exp_q.size() == 0, exp_q.size(), 0);
    endtask

    task automatic move(input int x, input int y, input int c,
                        output int nw, output int idle, output bit fv);
        bit st;
        seg_start(x, y, c, st, fv);
        seg_finish(st, idle);
        nw = writes - seg_w0;
    endtask

    task automatic pen_up();
        left_button = 1'b0;
        m_pen = 1'b0;
        repeat (2) @(posedge CLOCK_50);
        #1;
    endtask

    initial begin
        int  nw, idle, r, tx, ty, cap_x, cap_y, w;
        bit  fv, st;

        fork
            monitor();
        join_none

        repeat (3) @(posedge CLOCK_50);
        #1;
        chk("reset_valid", !pix.pix_valid, int'(pix.pix_valid), 0);
        chk("reset_busy", !busy, int'(busy), 0);
        chk("reset_x", pix.pix_x == 0, int'(pix.pix_x), 0);
        chk("reset_y", pix.pix_y == 0, int'(pix.pix_y), 0);
        chk("reset_colour", pix.pix_colour == 0, int'(pix.pix_colour), 0);
        reset = 1'b0;
        @(posedge CLOCK_50);
        #1;

        // Single dot, then a horizontal segment from it
        move(320, 240, 4, nw, idle, fv);
        chk("dot_first_valid", fv, int'(fv), 1);
        chk("dot_writes", nw == 9, nw, 9);
        move(324, 240, 4, nw, idle, fv);
        chk("hline_writes", nw == 45, nw, 45);
        chk("hline_step_cycles", idle == 4, idle, 4);

        // Steep diagonal: 7 line points
        pen_up();
        move(100, 100, 2, nw, idle, fv);
        move(103, 106, 5, nw, idle, fv);
        chk("diag_writes", nw == 63, nw, 63);

        // Clamped corner dot
        pen_up();
        move(-5, 0, 7, nw, idle, fv);
        chk("corner_writes", nw == 4, nw, 4);
        chk("corner_skips", idle == 5, idle, 5);

        // Back-pressure mid-stamp
        pen_up();
        seg_start(200, 200, 6, st, fv);
        ready_mode = 2;
        @(negedge CLOCK_50);
        cap_x = int'(pix.pix_x);
        cap_y = int'(pix.pix_y);
        for (int i = 0; i < 10; i++) begin
            @(negedge CLOCK_50);
            chk("stall_hold", pix.pix_valid && int'(pix.pix_x) == cap_x && int'(pix.pix_y) == cap_y,
                int'(pix.pix_x), cap_x);
        end
        ready_mode = 0;
        seg_finish(st, idle);
        chk("stall_total", (writes - seg_w0) == 9, writes - seg_w0, 9);

        // Randomized strokes with random back-pressure
        ready_mode = 1;
        for (int k = 0; k < 30; k++) begin
            r = int'($urandom_range(0, 9));
            if (r < 2) begin
                pen_up();
            end else if (r == 9) begin
                pen_up();
                tx = ($urandom_range(0, 1) == 1) ? 636 + int'($urandom_range(0, 10)) : int'($urandom_range(0, 6)) - 3;
                ty = ($urandom_range(0, 1) == 1) ? 476 + int'($urandom_range(0, 10)) : int'($urandom_range(0, 6)) - 3;
                move(tx, ty, int'($urandom_range(0, 7)), nw, idle, fv);
            end else begin
                tx = m_lx + int'($urandom_range(0, 60)) - 30;
                ty = m_ly + int'($urandom_range(0, 60)) - 30;
                move(tx, ty, int'($urandom_range(0, 7)), nw, idle, fv);
            end
        end
        ready_mode = 0;

        // Reset in the middle of a stroke
        pen_up();
        move(10, 10, 3, nw, idle, fv);
        seg_start(300, 200, 1, st, fv);
        repeat (5) @(negedge CLOCK_50);
        chk("pre_reset_valid", pix.pix_valid, int'(pix.pix_valid), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_valid", !pix.pix_valid, int'(pix.pix_valid), 0);
        chk("async_reset_busy", !busy, int'(busy), 0);
        exp_q.delete();
        m_pen = 1'b0;
        m_lx = 0;
        m_ly = 0;
        left_button = 1'b0;
        w = writes;
        @(posedge CLOCK_50);
        #1;
        reset = 1'b0;
        repeat (20) @(negedge CLOCK_50);
        chk("post_reset_no_writes", writes == w, writes - w, 0);
        chk("post_reset_idle", !busy, int'(busy), 0);
        @(posedge CLOCK_50);
        #1;
        move(50, 60, 5, nw, idle, fv);
        chk("post_reset_dot", nw == 9, nw, 9);

        chk("final_queue_empty", exp_q.size() == 0, exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/brush_stroke_plotter.md
Name: brush_stroke_plotter

Overview:
- Sits directly downstream of the PS/2 mouse decoder; consumes its cursor position and left-button outputs.
- While the left button is held, draws a continuous stroke into the VGA framebuffer.
- Joins successive cursor samples with a Bresenham line and stamps a square brush at every line point.
- Emits one framebuffer pixel write per accepted valid/ready handshake.

Parameters:
- BRUSH, 3: brush edge in pixels; odd, 1..15; half-width H = (BRUSH-1)/2.
- SCREEN_W, 640: visible width; legal x range 0..SCREEN_W-1.
- SCREEN_H, 480: visible height; legal y range 0..SCREEN_H-1.
- COLOUR_W, 3: colour width.

Ports:
- CLOCK_50  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- cursor_x  in  11 (signed)  cursor x from the mouse decoder.
- cursor_y  in  11 (signed)  cursor y from the mouse decoder.
- left_button  in  1  1 = pen down.
- colour_in  in  COLOUR_W  paint colour; latched at each stroke-segment start.
- pix_ready  in  1  framebuffer accepts a write this cycle.
- pix_valid  out  1  write request.
- pix_x  out  10  write x.
- pix_y  out  9  write y.
- pix_colour  out  COLOUR_W  write colour.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset:
  - Asynchronous; wins over everything, including a handshake in progress.
  - State = IDLE; pix_valid = busy = pen_down = 0.
  - pix_x, pix_y, pix_colour, last point and all line registers = 0.
  - A stroke interrupted by reset is abandoned; nothing is replayed.
- Input clamp (combinational):
  - cx = cursor_x limited to 0..SCREEN_W-1; cy = cursor_y limited to 0..SCREEN_H-1.
  - Negative values clamp to 0.
- States: IDLE, STAMP, STEP.
- IDLE:
  - left_button = 0: pen_down <= 0; stay in IDLE.
  - left_button = 1 and (pen_down = 0 or (cx,cy) != last):
    - end point (x1,y1) <= (cx,cy); colour latched from colour_in.
    - Start point (x0,y0) <= last if pen_down = 1, else (cx,cy), which gives a single dot.
    - Current point (px,py) <= (x0,y0).
    - dx = |x1-x0|; dy = -|y1-y0|; sx, sy = +1/-1 toward the end point.
    - err = dx + dy; signed 12-bit arithmetic, no overflow possible for 640x480.
    - pen_down <= 1; brush counters bx = by = 0; go to STAMP.
  - Otherwise stay in IDLE.
  - Cursor motion while busy is ignored; it is picked up on the next IDLE cycle, so strokes never gap.
- STAMP:
  - Candidate pixel = (px+bx-H, py+by-H); scan is row-major, bx inner, by outer.
  - In range: pix_valid = 1 with pix_x/pix_y/pix_colour = candidate. Outputs are held stable until pix_ready = 1; counters advance on the accepting edge.
  - Out of range: pix_valid = 0; counters advance after one cycle (clipping).
  - After the last brush pixel (bx = by = BRUSH-1, accepted or skipped):
    - If (px,py) == (x1,y1): last <= (x1,y1); go to IDLE.
    - Else go to STEP.
- STEP (one cycle, pix_valid = 0):
  - e2 = 2*err.
  - If e2 >= dy: err += dy; px += sx.
  - If e2 <= dx: err += dx; py += sy.
  - Both comparisons use the pre-update err.
  - bx = by = 0; go to STAMP.
- Latency:
  - First pix_valid appears 1 cycle after the IDLE decision edge.
  - Each line point costs BRUSH^2 handshake/skip cycles + 1 STEP cycle.
- Button released mid-segment: the current segment completes; IDLE then clears pen_down. The next press starts a fresh dot, with no line from the old point.
- Overlapping stamps write pixels repeatedly; this is acceptable and not deduplicated.

Test Plan:
- Reset, left_button=1, cursor (320,240), colour 3'b100, BRUSH=3, pix_ready=1 -> exactly 9 writes covering x 319..321, y 239..241, row-major, colour 4; busy drops; last = (320,240).
- After the dot, cursor -> (324,240) -> 5 stamps centred x=320..324, y=240; 45 writes total; no writes to y outside 239..241.
- Diagonal (100,100) -> (103,106) -> line point sequence matches the Bresenham reference model; every point stamped; final point (103,106).
- Dot at cursor (-5,0) (clamped to 0,0) -> 4 writes only: (0,0),(1,0),(0,1),(1,1); 5 skip cycles with pix_valid=0.
- pix_ready held 0 for 10 cycles mid-stamp -> pix_valid, pix_x, pix_y stable throughout; no counter advance; resumes on pix_ready=1.
- Assert reset with pix_valid=1 mid-stroke -> pix_valid=0 and busy=0 immediately (asynchronous); after release with left_button=0 -> no writes.
